// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel-timing generator driven by the PLL pixel clock.
// It free-runs horizontal and vertical counters while the (synchronized) PLL
// lock is present, and holds everything in the idle/reset state otherwise.
//
// Ports
//   clk         pixel clock from PLL clkout0
//   reset_n     asynchronous active-low reset
//   pll_locked  PLL lock, asynchronous to clk, active high
//   h_pos       horizontal count, 0..H_TOTAL-1
//   v_pos       vertical count, 0..V_TOTAL-1
//   de          data enable (visible region)
//   hsync       horizontal sync, at H_SYNC_POL while active
//   vsync       vertical sync, at V_SYNC_POL while active
//   line_start  one-cycle pulse on h_pos==0
//   frame_start one-cycle pulse on h_pos==0 && v_pos==0
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pll_locked,
  output logic [CW-1:0] h_pos,
  output logic [CW-1:0] v_pos,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sized constants so every compare is CW bits wide.
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          lk1_q, lk2_q;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk1_q <= 1'b0;
      lk2_q <= 1'b0;
    end else begin
      lk1_q <= pll_locked;
      lk2_q <= lk1_q;
    end
  end

  // Next-count and output decode. Outputs are decoded from the next counts so
  // the registered strobes/syncs line up with the registered positions.
  always_comb begin
    h_cnt_d = H_LAST;
    v_cnt_d = V_LAST;
    if (lk2_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
    end
    de_d = lk2_q && (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
    hs_d = (lk2_q && (h_cnt_d >= HS_BEG) && (h_cnt_d < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    // v_cnt only moves when h wraps, so vsync changes on the h_pos==0 edge.
    vs_d = (lk2_q && (v_cnt_d >= VS_BEG) && (v_cnt_d < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    ls_d = lk2_q && (h_cnt_d == '0);
    fs_d = lk2_q && (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= H_LAST;
      v_cnt_q <= V_LAST;
      de_q    <= 1'b0;
      hs_q    <= ~H_SYNC_POL;
      vs_q    <= ~V_SYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign h_pos       = h_cnt_q;
  assign v_pos       = v_cnt_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
